// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants for the memory-access stage: EX/MEM bundle
//               bit positions, load/store variant codes, FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_BUNDLE_W   = 113;
    localparam int c_RD_LO      = 0;
    localparam int c_RD_HI      = 4;
    localparam int c_ALU_LO     = 5;
    localparam int c_ALU_HI     = 36;
    localparam int c_PC_LO      = 37;
    localparam int c_PC_HI      = 68;
    localparam int c_IS_LOAD    = 69;
    localparam int c_IS_STORE   = 70;
    localparam int c_IS_CALL    = 71;
    localparam int c_REG_WRITE  = 72;
    localparam int c_IS_AUIPC   = 73;
    localparam int c_RS2_LO     = 74;
    localparam int c_RS2_HI     = 105;
    localparam int c_BRANCH     = 106;
    localparam int c_LV_LO      = 107;
    localparam int c_LV_HI      = 109;
    localparam int c_SV_LO      = 110;
    localparam int c_SV_HI      = 112;

    localparam logic [2:0] c_LV_LB  = 3'b000;
    localparam logic [2:0] c_LV_LH  = 3'b001;
    localparam logic [2:0] c_LV_LW  = 3'b010;
    localparam logic [2:0] c_LV_LBU = 3'b100;
    localparam logic [2:0] c_LV_LHU = 3'b101;

    localparam logic [2:0] c_SV_SB  = 3'b000;
    localparam logic [2:0] c_SV_SH  = 3'b001;
    localparam logic [2:0] c_SV_SW  = 3'b010;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

    // Unknown load codes are sized as bytes so they never count as misaligned.
    function automatic logic [1:0] f_access_size(input logic       is_store,
                                                 input logic [2:0] lv,
                                                 input logic [2:0] sv);
        logic [2:0] v;
        v = is_store ? sv : lv;
        if (v == c_LV_LW)
            return c_SIZE_WORD;
        else if (v == c_LV_LH || (!is_store && v == c_LV_LHU))
            return c_SIZE_HALF;
        else
            return c_SIZE_BYTE;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half/word lane of a load response
//               and sign- or zero-extends it. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_variant,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = 32'd0;
        case (i_variant)
            c_LV_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            c_LV_LH:  o_data = {{16{w_half[15]}}, w_half};
            c_LV_LW:  o_data = i_rdata;
            c_LV_LBU: o_data = {24'd0, w_byte};
            c_LV_LHU: o_data = {16'd0, w_half};
            default:  o_data = 32'd0;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage: issues data-memory requests, stalls while
//               waiting, aligns loads and registers the MEM/WB word.
//               Optional macro MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [c_BUNDLE_W-1:0] i_em_bundle,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [31:0]           o_dmem_addr,
    output logic [31:0]           o_dmem_wdata,
    output logic [3:0]            o_dmem_be,
    input  logic [31:0]           i_dmem_rdata,
    input  logic                  i_dmem_ready,
    output logic                  o_mem_stall,
    output logic [4:0]            o_mw_rd,
    output logic [31:0]           o_mw_wb_data,
    output logic                  o_mw_reg_write,
    output logic                  o_mw_should_branch,
    output logic                  o_mw_misalign
);

    logic [4:0]  w_rd;
    logic [31:0] w_alu;
    logic [31:0] w_pc;
    logic [31:0] w_rs2;
    logic [2:0]  w_lv;
    logic [2:0]  w_sv;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_call;
    logic        w_reg_write;
    logic        w_branch;
    logic        w_store_ok;
    logic [1:0]  w_size;
    logic        w_trap;
    logic [31:0] w_addr;
    logic        w_mem_op;
    logic        w_req;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic        w_unused_auipc;

    mem_state_t  r_state;
    logic [4:0]  r_mw_rd;
    logic [31:0] r_mw_wb_data;
    logic        r_mw_reg_write;
    logic        r_mw_should_branch;
    logic        r_mw_misalign;

    assign w_rd        = i_em_bundle[c_RD_HI:c_RD_LO];
    assign w_alu       = i_em_bundle[c_ALU_HI:c_ALU_LO];
    assign w_pc        = i_em_bundle[c_PC_HI:c_PC_LO];
    assign w_rs2       = i_em_bundle[c_RS2_HI:c_RS2_LO];
    assign w_lv        = i_em_bundle[c_LV_HI:c_LV_LO];
    assign w_sv        = i_em_bundle[c_SV_HI:c_SV_LO];
    assign w_is_store  = i_em_bundle[c_IS_STORE];
    assign w_is_load   = i_em_bundle[c_IS_LOAD] & ~w_is_store;
    assign w_is_call   = i_em_bundle[c_IS_CALL];
    assign w_reg_write = i_em_bundle[c_REG_WRITE];
    assign w_branch    = i_em_bundle[c_BRANCH];
    // AUIPC results already arrive on alu_result; the flag needs no handling.
    assign w_unused_auipc = i_em_bundle[c_IS_AUIPC];

    assign w_store_ok = (w_sv == c_SV_SB) || (w_sv == c_SV_SH) || (w_sv == c_SV_SW);
    assign w_size     = f_access_size(w_is_store, w_lv, w_sv);

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = ((w_size == c_SIZE_HALF) && w_alu[0]) ||
                          ((w_size == c_SIZE_WORD) && (w_alu[1:0] != 2'b00));
    assign w_trap = (w_is_load | (w_is_store & w_store_ok)) & w_misaligned;
    assign w_addr = w_alu;
`else
    assign w_trap = 1'b0;
    always_comb begin
        w_addr = w_alu;
        if (w_size == c_SIZE_WORD)
            w_addr[1:0] = 2'b00;
        else if (w_size == c_SIZE_HALF)
            w_addr[0] = 1'b0;
    end
`endif

    assign w_mem_op = (w_is_load | (w_is_store & w_store_ok)) & ~w_trap;
    // Requests are masked during reset so nothing leaks out of an abandoned access.
    assign w_req    = ~reset & ((r_state == S_WAIT) | w_mem_op);

    assign o_dmem_req  = w_req;
    assign o_mem_stall = w_req & ~i_dmem_ready;
    assign o_dmem_we   = w_is_store;
    assign o_dmem_addr = w_addr;

    always_comb begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = w_rs2;
        if (w_is_store) begin
            case (w_sv)
                c_SV_SB: begin
                    o_dmem_be    = 4'b0001 << w_addr[1:0];
                    o_dmem_wdata = {4{w_rs2[7:0]}};
                end
                c_SV_SH: begin
                    o_dmem_be    = 4'b0011 << w_addr[1:0];
                    o_dmem_wdata = {2{w_rs2[15:0]}};
                end
                default: begin
                    o_dmem_be    = 4'b1111;
                    o_dmem_wdata = w_rs2;
                end
            endcase
        end
    end

    load_align u_load_align (
        .i_addr_lo (w_addr[1:0]),
        .i_variant (w_lv),
        .i_rdata   (i_dmem_rdata),
        .o_data    (w_load_data)
    );

    always_comb begin
        if (w_is_load)
            w_wb_data = w_load_data;
        else if (w_is_call)
            w_wb_data = w_pc + 32'd4;
        else
            w_wb_data = w_alu;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_mw_rd            <= 5'd0;
            r_mw_wb_data       <= 32'd0;
            r_mw_reg_write     <= 1'b0;
            r_mw_should_branch <= 1'b0;
            r_mw_misalign      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_mem_op && !i_dmem_ready) r_state <= S_WAIT;
                S_WAIT: if (i_dmem_ready)              r_state <= S_IDLE;
                default:                               r_state <= S_IDLE;
            endcase

            if (o_mem_stall) begin
                r_mw_rd            <= 5'd0;
                r_mw_wb_data       <= 32'd0;
                r_mw_reg_write     <= 1'b0;
                r_mw_should_branch <= 1'b0;
                r_mw_misalign      <= 1'b0;
            end else begin
                r_mw_rd            <= w_rd;
                r_mw_wb_data       <= w_wb_data;
                r_mw_reg_write     <= w_reg_write & (w_rd != 5'd0) & ~w_is_store & ~w_trap;
                r_mw_should_branch <= w_branch;
                r_mw_misalign      <= w_trap;
            end
        end
    end

    assign o_mw_rd            = r_mw_rd;
    assign o_mw_wb_data       = r_mw_wb_data;
    assign o_mw_reg_write     = r_mw_reg_write;
    assign o_mw_should_branch = r_mw_should_branch;
    assign o_mw_misalign      = r_mw_misalign;

endmodule : mem_access_stage
`default_nettype wire
